pl_hazard_controller: RTL and testbench

//  Drives the enable and flush controls of the IF/ID, ID/EX and EX/MEM pipeline registers and the PC.

---
 rtl/pl_pipeline_pkg.sv | 17 +
 rtl/pl_sat_counter.sv | 36 +++
 rtl/pl_hazard_controller.sv | 134 +++++++++++++
 tb/tb_pl_hazard_controller.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pl_pipeline_pkg.sv
// rtl/pl_pipeline_pkg.sv - shared pipeline control types and constants
// Contents: hazard-controller FSM encoding, register-zero address, default
//           register-file address width.
package pl_pipeline_pkg;

   localparam int unsigned DEF_REG_ADDR_W = 5;

   // Register 0 is hardwired to zero, so a load targeting it never creates
   // a real dependency.
   localparam int unsigned ZERO_REG = 0;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MUL_WAIT = 1'b1
   } hz_state_e;

endpackage

// File: rtl/pl_sat_counter.sv
// rtl/pl_sat_counter.sv - saturating up-counter for pipeline statistics
// Ports:
//   clk    in   1  clock, rising edge
//   reset  in   1  asynchronous, active-low; clears count
//   inc    in   1  increment request for this cycle
//   count  out  W  current value; holds at all-ones instead of wrapping
module pl_sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pl_hazard_controller.sv
// rtl/pl_hazard_controller.sv - pipeline stall/flush controller
// Resolves load-use hazards (stall + bubble), taken branches (squash the two
// younger instructions) and multi-cycle multiplies (freeze front of pipe).
// Ports:
//   clk, reset                  clock; asynchronous active-low reset
//   id_rs, id_rt, id_uses_rt    source operands of the instruction in ID
//   ex_mem_read, ex_rt          load in EX and its destination register
//   ex_branch_taken             branch in EX resolved taken
//   ex_mul_start                instruction in EX is a multiply
//   pc_enable, ifid_enable, idex_enable, exmem_enable   register enables
//   ifid_flush, idex_flush      datapath inserts a NOP/bubble
//   mul_busy, mul_done          multiply freeze in progress / release cycle
//   stall_count, flush_count    saturating statistics counters
module pl_hazard_controller
   import pl_pipeline_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int unsigned MUL_CYCLES = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rt,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   input  logic                  ex_branch_taken,
   input  logic                  ex_mul_start,
   output logic                  pc_enable,
   output logic                  ifid_enable,
   output logic                  ifid_flush,
   output logic                  idex_enable,
   output logic                  idex_flush,
   output logic                  exmem_enable,
   output logic                  mul_busy,
   output logic                  mul_done,
   output logic [CNT_W-1:0]      stall_count,
   output logic [CNT_W-1:0]      flush_count
);

   localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES - 1);

   hz_state_e  state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       load_use;
   logic       flush_evt;

   assign load_use = ex_mem_read
                     && (ex_rt != REG_ADDR_W'(ZERO_REG))
                     && ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      pc_enable    = 1'b1;
      ifid_enable  = 1'b1;
      ifid_flush   = 1'b0;
      idex_enable  = 1'b1;
      idex_flush   = 1'b0;
      exmem_enable = 1'b1;
      mul_busy     = 1'b0;
      mul_done     = 1'b0;
      flush_evt    = 1'b0;

      // While reset is held the outputs stay at their defaults even if the
      // datapath is still presenting a multiply or hazard.
      if (reset) begin
         case (state_q)
            ST_RUN: begin
               if (ex_mul_start) begin
                  pc_enable    = 1'b0;
                  ifid_enable  = 1'b0;
                  idex_enable  = 1'b0;
                  exmem_enable = 1'b0;
                  mul_busy     = 1'b1;
                  cnt_d        = MUL_LOAD;
                  state_d      = ST_MUL_WAIT;
               end else if (ex_branch_taken) begin
                  // The load-use stall would refer to a squashed instruction.
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
                  flush_evt  = 1'b1;
               end else if (load_use) begin
                  pc_enable   = 1'b0;
                  ifid_enable = 1'b0;
                  idex_flush  = 1'b1;
               end
            end
            ST_MUL_WAIT: begin
               if (cnt_q != 8'd0) begin
                  pc_enable    = 1'b0;
                  ifid_enable  = 1'b0;
                  idex_enable  = 1'b0;
                  exmem_enable = 1'b0;
                  mul_busy     = 1'b1;
                  cnt_d        = cnt_q - 8'd1;
               end else begin
                  // Release cycle: ex_mul_start is still high for the finishing
                  // multiply and is deliberately not looked at here.
                  mul_done = 1'b1;
                  state_d  = ST_RUN;
               end
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_RUN;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   pl_sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (~pc_enable),
      .count (stall_count)
   );

   pl_sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (flush_evt),
      .count (flush_count)
   );

endmodule

// File: tb/tb_pl_hazard_controller.sv
// tb/tb_pl_hazard_controller.sv - directed self-checking bench for pl_hazard_controller
module tb_pl_hazard_controller;

   logic       clk;
   logic       reset;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       id_uses_rt, ex_mem_read, ex_branch_taken, ex_mul_start;

   logic        pc_enable, ifid_enable, ifid_flush, idex_enable, idex_flush;
   logic        exmem_enable, mul_busy, mul_done;
   logic [15:0] stall_count, flush_count;

   logic        s_pc_enable, s_ifid_enable, s_ifid_flush, s_idex_enable, s_idex_flush;
   logic        s_exmem_enable, s_mul_busy, s_mul_done;
   logic [3:0]  s_stall_count, s_flush_count;

   int checks = 0;
   int errors = 0;

   pl_hazard_controller #(.REG_ADDR_W(5), .MUL_CYCLES(4), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .ex_branch_taken(ex_branch_taken), .ex_mul_start(ex_mul_start),
      .pc_enable(pc_enable), .ifid_enable(ifid_enable), .ifid_flush(ifid_flush),
      .idex_enable(idex_enable), .idex_flush(idex_flush), .exmem_enable(exmem_enable),
      .mul_busy(mul_busy), .mul_done(mul_done),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   pl_hazard_controller #(.REG_ADDR_W(5), .MUL_CYCLES(4), .CNT_W(4)) dut_sat (
      .clk(clk), .reset(reset),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .ex_branch_taken(ex_branch_taken), .ex_mul_start(ex_mul_start),
      .pc_enable(s_pc_enable), .ifid_enable(s_ifid_enable), .ifid_flush(s_ifid_flush),
      .idex_enable(s_idex_enable), .idex_flush(s_idex_flush), .exmem_enable(s_exmem_enable),
      .mul_busy(s_mul_busy), .mul_done(s_mul_done),
      .stall_count(s_stall_count), .flush_count(s_flush_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
      ex_mem_read = 1'b0; ex_rt = 5'd0;
      ex_branch_taken = 1'b0; ex_mul_start = 1'b0;
   endtask

   task automatic check_freeze(input string tag);
      check({tag, ".pc_en"},    32'(pc_enable),    32'd0);
      check({tag, ".ifid_en"},  32'(ifid_enable),  32'd0);
      check({tag, ".idex_en"},  32'(idex_enable),  32'd0);
      check({tag, ".exmem_en"}, 32'(exmem_enable), 32'd0);
      check({tag, ".busy"},     32'(mul_busy),     32'd1);
      check({tag, ".done"},     32'(mul_done),     32'd0);
   endtask

   initial begin
      clear_inputs();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
      #1;

      // 1: post-reset defaults
      check("rst.pc_en",    32'(pc_enable),    32'd1);
      check("rst.ifid_en",  32'(ifid_enable),  32'd1);
      check("rst.idex_en",  32'(idex_enable),  32'd1);
      check("rst.exmem_en", 32'(exmem_enable), 32'd1);
      check("rst.ifid_fl",  32'(ifid_flush),   32'd0);
      check("rst.idex_fl",  32'(idex_flush),   32'd0);
      check("rst.busy",     32'(mul_busy),     32'd0);
      check("rst.stall",    32'(stall_count),  32'd0);
      check("rst.flush",    32'(flush_count),  32'd0);
      check("rst.state",    32'(dut.state_q),  32'd0);
      step();

      // 2: load-use on rs
      ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
      #1;
      check("lu.pc_en",    32'(pc_enable),    32'd0);
      check("lu.ifid_en",  32'(ifid_enable),  32'd0);
      check("lu.idex_fl",  32'(idex_flush),   32'd1);
      check("lu.idex_en",  32'(idex_enable),  32'd1);
      check("lu.exmem_en", 32'(exmem_enable), 32'd1);
      check("lu.ifid_fl",  32'(ifid_flush),   32'd0);
      step();
      check("lu.stall", 32'(stall_count), 32'd1);

      // load to r0 never stalls
      ex_rt = 5'd0; id_rs = 5'd0;
      #1;
      check("lu0.pc_en",   32'(pc_enable),  32'd1);
      check("lu0.idex_fl", 32'(idex_flush), 32'd0);
      step();
      check("lu0.stall", 32'(stall_count), 32'd1);

      // load-use through rt only when rt is read
      ex_rt = 5'd5; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b1;
      #1;
      check("lurt.pc_en", 32'(pc_enable), 32'd0);
      step();
      id_uses_rt = 1'b0;
      #1;
      check("lurt_off.pc_en", 32'(pc_enable), 32'd1);
      step();
      check("lurt.stall", 32'(stall_count), 32'd2);

      // 3: branch overrides load-use
      ex_rt = 5'd8; id_rs = 5'd8; ex_branch_taken = 1'b1;
      #1;
      check("br.ifid_fl", 32'(ifid_flush),  32'd1);
      check("br.idex_fl", 32'(idex_flush),  32'd1);
      check("br.pc_en",   32'(pc_enable),   32'd1);
      check("br.ifid_en", 32'(ifid_enable), 32'd1);
      step();
      check("br.flush", 32'(flush_count), 32'd1);
      check("br.stall", 32'(stall_count), 32'd2);
      clear_inputs();

      // 4: multiply held high, 4 stall cycles then release
      ex_mul_start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         ex_branch_taken = (i == 2);
         #1;
         if (i < 4) begin
            check_freeze($sformatf("mul%0d", i));
            check($sformatf("mul%0d.ifid_fl", i), 32'(ifid_flush), 32'd0);
         end else begin
            check("mulrel.pc_en",    32'(pc_enable),    32'd1);
            check("mulrel.exmem_en", 32'(exmem_enable), 32'd1);
            check("mulrel.busy",     32'(mul_busy),     32'd0);
            check("mulrel.done",     32'(mul_done),     32'd1);
         end
         step();
      end
      check("mul.stall", 32'(stall_count), 32'd6);
      check("mul.flush", 32'(flush_count), 32'd1);

      // back-to-back multiply triggers in the next RUN cycle
      #1;
      check("b2b.state", 32'(dut.state_q), 32'd0);
      check_freeze("b2b");
      step();
      step();
      // 5: now on the 2nd MUL_WAIT cycle
      check_freeze("mw2");
      check("mw2.stall", 32'(stall_count), 32'd8);
      reset = 1'b0;
      #1;
      check("mrst.busy",     32'(mul_busy),     32'd0);
      check("mrst.pc_en",    32'(pc_enable),    32'd1);
      check("mrst.ifid_en",  32'(ifid_enable),  32'd1);
      check("mrst.exmem_en", 32'(exmem_enable), 32'd1);
      check("mrst.stall",    32'(stall_count),  32'd0);
      step();
      clear_inputs();
      #2;
      reset = 1'b1;
      step();
      check("mrel.state", 32'(dut.state_q), 32'd0);
      check("mrel.busy",  32'(mul_busy),    32'd0);
      check("mrel.stall", 32'(stall_count), 32'd0);
      check("mrel.flush", 32'(flush_count), 32'd0);

      // 6: saturation with CNT_W=4
      ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
      for (int i = 0; i < 20; i++) begin
         step();
         if (i == 14) check("sat15.stall", 32'(s_stall_count), 32'd15);
      end
      check("sat.stall",  32'(s_stall_count), 32'd15);
      check("wide.stall", 32'(stall_count),   32'd20);
      clear_inputs();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
